// File: rtl/team_06_audio_pkg.sv
// Shared types and constants for the audio PWM output stage.
package team_06_audio_pkg;

  typedef enum logic [1:0] {IDLE, PRIME, RUN} pwm_state_t;

  typedef logic [7:0] sample_t;

  localparam sample_t MIDSCALE = 8'h80;

endpackage

// File: rtl/team_06_sample_fifo.sv
// Small synchronous sample FIFO; push/pop are ignored when full/empty.
module team_06_sample_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array; contents need no reset since level gates all reads.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/team_06_audio_pwm_out.sv
// Audio output stage: buffers samples and plays them as a PWM bitstream.
module team_06_audio_pwm_out
  import team_06_audio_pkg::*;
#(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned PWM_PER_SAMPLE = 4,
  parameter int unsigned PRIME_LEVEL    = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic [DATA_W-1:0]               sample_in,
  input  logic                            sample_valid,
  output logic                            sample_ready,
  output logic                            sample_req,
  output logic                            pwm_out,
  output logic                            underrun,
  input  logic                            underrun_clr,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PER_W = (PWM_PER_SAMPLE > 1) ? $clog2(PWM_PER_SAMPLE) : 1;
  localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [PER_W-1:0]  PER_LAST = PER_W'(PWM_PER_SAMPLE - 1);

  pwm_state_t         state;
  pwm_state_t         state_nx;
  logic [DATA_W-1:0]  pwm_cnt;
  logic [PER_W-1:0]   per_cnt;
  logic [DATA_W-1:0]  duty;
  logic [DATA_W-1:0]  fifo_dout;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               boundary;
  logic               load_mid;
  logic               set_ur;
  logic               req_nx;

  assign sample_ready = !fifo_full;
  assign push         = sample_valid && !fifo_full;

  team_06_sample_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (sample_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next state and boundary actions; en=0 overrides everything.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    req_nx   = 1'b0;
    set_ur   = 1'b0;
    load_mid = 1'b0;
    boundary = (pwm_cnt == '1) && (per_cnt == PER_LAST);
    if (!en) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          state_nx = PRIME;
          load_mid = 1'b1;
        end
        PRIME: begin
          if (boundary && (fifo_level >= LVL_W'(PRIME_LEVEL))) begin
            pop      = 1'b1;
            req_nx   = 1'b1;
            state_nx = RUN;
          end
        end
        RUN: begin
          if (boundary) begin
            req_nx = 1'b1;
            if (!fifo_empty) begin
              pop = 1'b1;
            end else begin
              load_mid = 1'b1;
              set_ur   = 1'b1;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Counters, duty register, PWM output and status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_cnt    <= '0;
      per_cnt    <= '0;
      duty       <= MID;
      pwm_out    <= 1'b0;
      sample_req <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      if ((state == IDLE) || !en) begin
        pwm_cnt <= '0;
        per_cnt <= '0;
      end else begin
        pwm_cnt <= pwm_cnt + 1'b1;
        if (pwm_cnt == '1) per_cnt <= (per_cnt == PER_LAST) ? '0 : per_cnt + 1'b1;
      end
      if (pop)           duty <= fifo_dout;
      else if (load_mid) duty <= MID;
      // Gated by en so a disable silences the pin on the very next cycle.
      pwm_out    <= en && (state != IDLE) && (pwm_cnt < duty);
      sample_req <= req_nx;
      underrun   <= set_ur | (underrun & ~underrun_clr);
    end
  end

endmodule

// File: doc/team_06_audio_pwm_out.md
Name: team_06_audio_pwm_out

Overview:
Output end of the audio effect chain. It accepts processed 8-bit unsigned samples from the effect stage over a valid/ready handshake and buffers them in a small FIFO. It then emits one sample per sample period as a single-bit PWM stream that drives the board's RC-filtered speaker pin. It also supplies the sample-rate request pulse and an underrun flag for the upstream pipeline.

Parameters:
DATA_W, 8, sample width; also sets the PWM period to 2^DATA_W clocks.
FIFO_DEPTH, 4, sample buffer entries (power of 2, >=2).
PWM_PER_SAMPLE, 4, PWM periods per audio sample (sample period = PWM_PER_SAMPLE*2^DATA_W clocks).
PRIME_LEVEL, 2, FIFO occupancy required before playback starts (1..FIFO_DEPTH).

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low (0 = reset)
en  in  1  playback enable
sample_in  in  DATA_W  processed audio sample, unsigned, midscale 0x80 = silence
sample_valid  in  1  sample_in valid
sample_ready  out  1  FIFO can accept (= !full, from registered state)
sample_req  out  1  one-cycle pulse each time a new duty value is loaded
pwm_out  out  1  registered PWM output
underrun  out  1  sticky; set when a sample boundary finds the FIFO empty in RUN
underrun_clr  in  1  synchronous clear of underrun
fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset (rst=0, async): FIFO empty, pwm_cnt=0, per_cnt=0, duty=0x80, state=IDLE, pwm_out=0, sample_req=0, underrun=0, fifo_level=0, sample_ready=1.
- Push: push occurs when sample_valid && sample_ready. It is accepted regardless of en or state. Level updates the next cycle.
- Push while full: not accepted; ready is 0. This holds even when a pop occurs in the same cycle, because ready comes from registered full.
- Push and pop in the same cycle (not full): both occur; level is unchanged.
- pwm_cnt: DATA_W-bit counter that increments every clock when state!=IDLE and wraps 2^DATA_W-1 -> 0.
- per_cnt: increments when pwm_cnt wraps and wraps at PWM_PER_SAMPLE-1.
- Sample boundary: the cycle with pwm_cnt==2^DATA_W-1 and per_cnt==PWM_PER_SAMPLE-1.
- pwm_out is registered: pwm_out <= (state!=IDLE) && (pwm_cnt < duty), giving one clock of latency. duty=0 gives constant low; duty=0xFF gives high for 255 of 256 clocks.
- FSM states: IDLE, PRIME, RUN.
  - IDLE: counters held at 0, pwm_out=0, duty held. en=1 -> PRIME next cycle, with duty loaded to 0x80.
  - PRIME: PWM runs with duty 0x80. At a boundary, if fifo_level >= PRIME_LEVEL, pop into duty, pulse sample_req, and go to RUN. Otherwise stay in PRIME; no pop, no underrun.
  - RUN: at each boundary, if the FIFO is non-empty, pop into duty and pulse sample_req. If empty, load duty=0x80, pulse sample_req, and set underrun. State stays RUN.
  - A push in the boundary cycle itself is not visible to that boundary's empty check.
  - en=0 in any state -> IDLE next cycle. Counters clear and FIFO contents are kept. A partially played period is discarded.
- underrun_clr: clears underrun the next cycle. If a set occurs in the same cycle as a clear, set wins.
- New duty applies starting with the pwm_cnt==0 cycle after the boundary.
- sample_req is high exactly one cycle per boundary in PRIME-with-pop and RUN, and never in IDLE.

Decomposition:
- Package team_06_audio_pkg holds:
  - typedef enum logic [1:0] {IDLE, PRIME, RUN} pwm_state_t;
  - localparam MIDSCALE = 8'h80;
  - the sample_t typedef (logic [7:0]).
- One sub-module, team_06_sample_fifo: synchronous FIFO parameterised by width and depth, with push/pop/full/empty/level ports.
- The top level contains the counters, FSM, duty register and flags.

Test Plan:
- Reset mid-playback: after rst=0 then rst=1, outputs are pwm_out=0, sample_ready=1, fifo_level=0, underrun=0, and state is IDLE; no sample_req for 2000 cycles with en=0.
- PRIME gating (PWM_PER_SAMPLE=1): en=1, push 0x40 at cycle 10 and none after -> no pop at the first boundary. Push 0xC0 -> at the next boundary, pop 0x40, sample_req pulse, and pwm_out high for exactly 64 of the following 256 clocks.
- Duty extremes (PWM_PER_SAMPLE=1, RUN): samples 0x00, 0xFF, 0x80 -> high counts of 0, 255 and 128 per 256-clock window, with one sample_req per window.
- Full/backpressure: with en=0, hold valid and push 6 samples -> 4 accepted, sample_ready=0 and fifo_level=4; the 5th is accepted only after the first RUN pop.
- Underrun: in RUN with an empty FIFO -> at the boundary, duty=0x80 (128 high clocks) and underrun=1, which stays set. Raise underrun_clr in the same cycle as a second underrun boundary -> underrun stays 1; clear it in a later cycle -> 0.
- Disable mid-period: drop en at pwm_cnt=100 -> pwm_out=0 from the next cycle. Re-enable -> state PRIME, duty 0x80, and the FIFO level is preserved.
